digi_ota_seq: RTL and testbench
===============================

Name: digi_ota_seq

Overview:
- Measurement sequencer for the digital OTA/comparator macro on the analog pins.
- On a start request it enables the OTA and waits a fixed settle time. It then samples the comparator output for a programmable window and counts the cycles where the output was high (output density).
- It presents the result on a valid/ready handshake to the host logic on the ui/uo/uio side.

Parameters:
- SETTLE_CYCLES, 16, cycles between OTA enable and first sample; must be >= SYNC_STAGES.
- CNT_W, 8, width of window length and result counters; max window 2^CNT_W-1.
- SYNC_STAGES, 2, flop stages on the asynchronous comparator input.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle measurement request
- abort  in  1  cancel current measurement
- win_len  in  CNT_W  number of sample cycles; latched on accepted start
- cmp_in  in  1  raw comparator/OTA digital output (asynchronous)
- ota_en  out  1  enable to OTA macro
- busy  out  1  high in any state other than IDLE
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_ones  out  CNT_W  count of synchronized-high samples
- res_len  out  CNT_W  latched window length for this result
- dropped_start  out  1  sticky: start arrived while a result was pending; cleared by rst only

Behaviour:
- Reset (async, rst=1):
  - State is IDLE.
  - All outputs are 0: ota_en, busy, res_valid, res_ones, res_len, dropped_start.
  - Synchronizer flops and counters are cleared.
- Synchronizer: cmp_s is cmp_in delayed through SYNC_STAGES flops. Only cmp_s is counted.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 and abort=0 at edge k: latch L=win_len and clear the ones counter.
  - If L=0: go to DONE, ota_en stays 0, res_ones=0, res_len=0.
  - If L>0: go to SETTLE and set ota_en=1 from edge k.
- SETTLE:
  - Settle counter runs for SETTLE_CYCLES edges.
  - At edge k+SETTLE_CYCLES, go to SAMPLE.
- SAMPLE:
  - At each of L edges, the ones counter increments by cmp_s.
  - At the L-th edge (k+SETTLE_CYCLES+L): go to DONE, ota_en=0, res_valid=1, res_ones/res_len loaded.
  - Latency is start edge to res_valid = SETTLE_CYCLES+L cycles. For L=0 the latency is 1 cycle.
- DONE:
  - res_valid, res_ones and res_len are held stable until res_valid & res_ready at an edge.
  - Handshake with start=0: go to IDLE, res_valid=0.
  - Handshake with start=1: back-to-back start; latch new win_len and go directly to SETTLE (or DONE if the new L=0). res_valid drops for at least one cycle.
  - start=1 with res_ready=0: start is ignored and dropped_start is set.
- Arithmetic: the ones counter cannot exceed L, so no saturation is needed. The settle counter width is clog2(SETTLE_CYCLES+1).
- abort (any state except IDLE):
  - Next edge goes to IDLE with ota_en=0, res_valid=0 and counters cleared. A pending result is discarded.
  - abort has priority over start and res_ready in the same cycle.
  - abort in IDLE has no effect.
- win_len changes after an accepted start have no effect on the current measurement.
- Reset mid-operation: all outputs deassert immediately, without waiting for a clock edge.

Decomposition:
- Shared package digi_ota_pkg contains:
  - state enum type (IDLE, SETTLE, SAMPLE, DONE);
  - default constants for SETTLE_CYCLES, CNT_W and SYNC_STAGES.
- Sub-module digi_ota_sync: SYNC_STAGES-deep synchronizer with async active-high reset. Instantiated once for cmp_in.

Test Plan (SETTLE_CYCLES=16, CNT_W=8, SYNC_STAGES=2):
- cmp_in=1 constant, win_len=10, start pulse -> ota_en high 26 cycles; res_valid rises 26 cycles after start edge; res_ones=10, res_len=10.
- cmp_in toggling every clk, win_len=100 -> res_ones=50, res_len=100, no change while res_ready=0.
- Measurement in progress, abort at cycle 20 after start -> next cycle ota_en=0, busy=0; res_valid never asserts; a new start measures correctly.
- res_ready held 0 for 5 cycles with a start pulse in DONE -> result held, dropped_start=1. Then res_ready=1 with start=1 same cycle -> res_valid low next cycle, busy stays 1, new result after 16+L cycles.
- win_len=0, start -> res_valid one cycle later, res_ones=0, res_len=0, ota_en never high.
- rst asserted mid-SAMPLE (between edges) -> ota_en, busy, res_valid drop immediately. After release, a normal start on cmp_in=0 with win_len=5 gives res_ones=0.

Source files
------------

// File: rtl/digi_ota_pkg.sv
// Shared types and default parameters for the OTA/comparator measurement sequencer.
package digi_ota_pkg;

    localparam int unsigned SETTLE_CYCLES_DEF = 16;
    localparam int unsigned CNT_W_DEF         = 8;
    localparam int unsigned SYNC_STAGES_DEF   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/digi_ota_sync.sv
// Multi-flop synchronizer for the asynchronous comparator output.
module digi_ota_sync
    import digi_ota_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | STAGES'(d);
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/digi_ota_seq.sv
// Measurement sequencer: enable OTA, settle, count synchronized-high comparator
// samples over a programmable window, then offer the result on valid/ready.
module digi_ota_seq
    import digi_ota_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] win_len,
    input  logic             cmp_in,
    output logic             ota_en,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_ones,
    output logic [CNT_W-1:0] res_len,
    output logic             dropped_start
);

    localparam int unsigned     SET_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    state_t           state, state_n;
    logic [SET_W-1:0] set_cnt, set_cnt_n;
    logic [CNT_W-1:0] win, win_n;
    logic [CNT_W-1:0] smp_cnt, smp_cnt_n;
    logic [CNT_W-1:0] ones, ones_n;
    logic [CNT_W-1:0] res_ones_n, res_len_n;
    logic             ota_en_n, busy_n, res_valid_n, dropped_n;
    logic             launch;
    logic             cmp_s;

    digi_ota_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_in),
        .q   (cmp_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            set_cnt       <= '0;
            win           <= '0;
            smp_cnt       <= '0;
            ones          <= '0;
            ota_en        <= 1'b0;
            busy          <= 1'b0;
            res_valid     <= 1'b0;
            res_ones      <= '0;
            res_len       <= '0;
            dropped_start <= 1'b0;
        end else begin
            state         <= state_n;
            set_cnt       <= set_cnt_n;
            win           <= win_n;
            smp_cnt       <= smp_cnt_n;
            ones          <= ones_n;
            ota_en        <= ota_en_n;
            busy          <= busy_n;
            res_valid     <= res_valid_n;
            res_ones      <= res_ones_n;
            res_len       <= res_len_n;
            dropped_start <= dropped_n;
        end
    end

    // A zero-length window enters DONE with res_valid low; DONE raises it one
    // cycle later, which also guarantees the drop on back-to-back starts.
    always_comb begin
        state_n     = state;
        set_cnt_n   = set_cnt;
        win_n       = win;
        smp_cnt_n   = smp_cnt;
        ones_n      = ones;
        ota_en_n    = ota_en;
        res_valid_n = res_valid;
        res_ones_n  = res_ones;
        res_len_n   = res_len;
        dropped_n   = dropped_start;
        launch      = 1'b0;

        case (state)
            IDLE: begin
                launch = start & ~abort;
            end
            SETTLE: begin
                if (set_cnt == SET_LAST) begin
                    state_n   = SAMPLE;
                    smp_cnt_n = '0;
                end else begin
                    set_cnt_n = set_cnt + SET_W'(1);
                end
            end
            SAMPLE: begin
                ones_n    = ones + CNT_W'(cmp_s);
                smp_cnt_n = smp_cnt + CNT_W'(1);
                if (smp_cnt == win - CNT_W'(1)) begin
                    state_n     = DONE;
                    ota_en_n    = 1'b0;
                    res_valid_n = 1'b1;
                    res_ones_n  = ones_n;
                    res_len_n   = win;
                end
            end
            DONE: begin
                if (!res_valid) begin
                    res_valid_n = 1'b1;
                end else if (res_ready) begin
                    res_valid_n = 1'b0;
                    if (start) begin
                        launch = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (start) begin
                    dropped_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (launch) begin
            win_n     = win_len;
            ones_n    = '0;
            set_cnt_n = '0;
            smp_cnt_n = '0;
            if (win_len == '0) begin
                state_n     = DONE;
                ota_en_n    = 1'b0;
                res_valid_n = 1'b0;
                res_ones_n  = '0;
                res_len_n   = '0;
            end else begin
                state_n  = SETTLE;
                ota_en_n = 1'b1;
            end
        end

        // Abort wins over start and res_ready; any pending result is discarded.
        if (abort && state != IDLE) begin
            state_n     = IDLE;
            ota_en_n    = 1'b0;
            res_valid_n = 1'b0;
            set_cnt_n   = '0;
            smp_cnt_n   = '0;
            ones_n      = '0;
            res_ones_n  = '0;
            res_len_n   = '0;
            dropped_n   = dropped_start;
        end

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_digi_ota_seq.sv
// Scoreboard bench for digi_ota_seq: expected results come from the driven
// comparator pattern, the window length and the settle/sync delays.
module tb_digi_ota_seq;

    localparam int S    = 16;
    localparam int W    = 8;
    localparam int Y    = 2;
    localparam int MAXC = 12000;

    typedef struct {
        int ones;
        int len;
        int rise;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, start, abort, cmp_in, res_ready;
    logic [W-1:0] win_len;
    logic         ota_en, busy, res_valid, dropped_start;
    logic [W-1:0] res_ones, res_len;

    bit   pat [0:MAXC];
    int   n = 0;
    exp_t q[$];
    int   total = 0;
    int   passed = 0;

    digi_ota_seq #(.SETTLE_CYCLES(S), .CNT_W(W), .SYNC_STAGES(Y)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .win_len       (win_len),
        .cmp_in        (cmp_in),
        .ota_en        (ota_en),
        .busy          (busy),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_ones      (res_ones),
        .res_len       (res_len),
        .dropped_start (dropped_start)
    );

    always #5 clk = ~clk;

    // n = number of rising edges so far; value driven here is sampled at edge n+1
    always @(posedge clk) n <= n + 1;
    always @(negedge clk) cmp_in = pat[n+1];

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act == exp_v) passed++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp_v, n);
    endtask

    // mode 0: all low, 1: all high, 2: toggle each cycle, 3: random
    task automatic fill(input int mode);
        for (int i = n + 1; i <= n + 400 && i <= MAXC; i++) begin
            case (mode)
                0: pat[i] = 1'b0;
                1: pat[i] = 1'b1;
                2: pat[i] = bit'(i % 2);
                default: pat[i] = bit'($urandom_range(0, 1));
            endcase
        end
    endtask

    // Called just after a falling edge; start is sampled at the next rising edge k.
    task automatic do_start(input int l, input bit accept);
        exp_t e;
        int   k;
        k = n + 1;
        win_len = W'(l);
        start = 1'b1;
        if (accept) begin
            e.len  = l;
            e.ones = 0;
            for (int j = 0; j < l; j++) e.ones += int'(pat[k + S + 1 - Y + j]);
            e.rise = (l == 0) ? k + 1 : k + S + l;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        win_len = W'($urandom);
    endtask

    task automatic wait_valid(input int budget);
        int i;
        i = 0;
        while (!res_valid && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (!res_valid) chk("res_valid_timeout", int'(res_valid), 1);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("valid_drop_after_handshake", int'(res_valid), 0);
    endtask

    // Monitor: compare each new result against the scoreboard, then check it holds.
    int   pv = 0;
    exp_t cur;
    always @(negedge clk) begin
        if (res_valid && pv == 0) begin
            chk("result_expected", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                cur = q.pop_front();
                chk("res_ones", int'(res_ones), cur.ones);
                chk("res_len", int'(res_len), cur.len);
                chk("latency_edge", n, cur.rise);
            end
        end else if (res_valid && pv == 1) begin
            chk("res_ones_stable", int'(res_ones), cur.ones);
            chk("res_len_stable", int'(res_len), cur.len);
        end
        pv = int'(res_valid);
    end

    initial begin
        int cnt, l, l2;
        rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0; win_len = '0;
        fill(0);
        repeat (3) @(negedge clk);
        chk("rst_ota_en", int'(ota_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_ones", int'(res_ones), 0);
        chk("rst_res_len", int'(res_len), 0);
        chk("rst_dropped", int'(dropped_start), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Constant high input, window 10
        fill(1);
        do_start(10, 1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cnt += int'(ota_en);
            @(negedge clk);
        end
        chk("ota_en_cycles_l10", cnt, S + 10);
        handshake();
        chk("idle_busy", int'(busy), 0);

        // Toggling input, window 100, consumer stalls
        fill(2);
        do_start(100, 1);
        wait_valid(S + 110);
        repeat (10) @(negedge clk);
        handshake();

        // Abort in the middle of sampling
        fill(3);
        do_start(200, 1);
        repeat (19) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        void'(q.pop_back());
        chk("abort_ota_en", int'(ota_en), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_res_valid", int'(res_valid), 0);
        repeat (250) @(negedge clk);
        fill(3);
        do_start(37, 1);
        wait_valid(S + 45);
        handshake();

        // Start while a result is pending, then back-to-back start on handshake
        fill(3);
        do_start(8, 1);
        wait_valid(S + 15);
        chk("dropped_before", int'(dropped_start), 0);
        do_start(20, 0);
        repeat (4) @(negedge clk);
        chk("dropped_set", int'(dropped_start), 1);
        chk("held_valid", int'(res_valid), 1);
        fill(3);
        res_ready = 1'b1;
        do_start(12, 1);
        res_ready = 1'b0;
        chk("b2b_valid_low", int'(res_valid), 0);
        chk("b2b_busy", int'(busy), 1);
        wait_valid(S + 20);
        handshake();
        chk("dropped_sticky", int'(dropped_start), 1);

        // Zero-length window
        fill(1);
        do_start(0, 1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cnt += int'(ota_en);
            @(negedge clk);
        end
        chk("l0_ota_en_cycles", cnt, 0);
        handshake();

        // Randomized measurements, some chained back-to-back
        for (int t = 0; t < 10; t++) begin
            fill(3);
            l = $urandom_range(0, 60);
            do_start(l, 1);
            wait_valid(S + l + 5);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                fill(3);
                l2 = $urandom_range(0, 40);
                res_ready = 1'b1;
                do_start(l2, 1);
                res_ready = 1'b0;
                wait_valid(S + l2 + 5);
            end
            handshake();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset between edges in the middle of sampling
        fill(1);
        do_start(50, 1);
        repeat (S + 10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        void'(q.pop_back());
        chk("async_rst_ota_en", int'(ota_en), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_res_valid", int'(res_valid), 0);
        chk("async_rst_dropped", int'(dropped_start), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill(0);
        do_start(5, 1);
        wait_valid(S + 10);
        handshake();

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
